// File: rtl/fpu_arb_pkg.sv
// Shared types for the FPU share arbiter.
// apu_ID_o carries the winning core index, zero-extended to ID_WIDTH.
package fpu_arb_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } arb_state_e;

    function automatic int core_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fpu_rr_arbiter.sv
// Combinational round-robin picker; the search starts at ptr and wraps.
module fpu_rr_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = core_idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);

    int c;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        c     = 0;
        for (int i = 0; i < N; i++) begin
            c = (int'(ptr) + i) % N;
            if (!valid && req[c]) begin
                valid  = 1'b1;
                idx    = IW'(c);
                gnt[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_share_arbiter.sv
// Shares one FPU between NB_CORES cores with round-robin issue and halt/drain.
// Define FPU_ARB_PERF_CNT_EN to add per-core stall counters (perf_stall_o).
module fpu_share_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int NB_CORES        = 4,
    parameter int ID_WIDTH        = 9,
    parameter int NB_ARGS         = 3,
    parameter int OPCODE_WIDTH    = 6,
    parameter int DATA_WIDTH      = 32,
    parameter int FLAGS_IN_WIDTH  = 15,
    parameter int FLAGS_OUT_WIDTH = 5,
    parameter int MAX_OUTSTANDING = 4,
    localparam int CW = core_idx_w(NB_CORES),
    localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [NB_CORES-1:0]                            core_req_i,
    output logic [NB_CORES-1:0]                            core_gnt_o,
    input  logic [NB_CORES-1:0][NB_ARGS-1:0][DATA_WIDTH-1:0] core_operands_i,
    input  logic [NB_CORES-1:0][OPCODE_WIDTH-1:0]          core_op_i,
    input  logic [NB_CORES-1:0][FLAGS_IN_WIDTH-1:0]        core_flags_i,
    output logic [NB_CORES-1:0]                            core_rvalid_o,
    output logic [DATA_WIDTH-1:0]                          core_rdata_o,
    output logic [FLAGS_OUT_WIDTH-1:0]                     core_rflags_o,
    output logic                                           apu_req_o,
    input  logic                                           apu_gnt_i,
    output logic [ID_WIDTH-1:0]                            apu_ID_o,
    output logic [NB_ARGS-1:0][DATA_WIDTH-1:0]             apu_operands_o,
    output logic [OPCODE_WIDTH-1:0]                        apu_op_o,
    output logic [FLAGS_IN_WIDTH-1:0]                      apu_flags_o,
    input  logic                                           apu_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                          apu_rdata_i,
    input  logic [FLAGS_OUT_WIDTH-1:0]                     apu_rflags_i,
    input  logic [ID_WIDTH-1:0]                            apu_rID_i,
    input  logic                                           halt_req_i,
    output logic                                           halt_ack_o,
    output logic [OW-1:0]                                  outstanding_o,
    output logic                                           err_o
`ifdef FPU_ARB_PERF_CNT_EN
    ,
    output logic [NB_CORES-1:0][31:0]                      perf_stall_o
`endif
);

    generate
        if ($clog2(NB_CORES) > ID_WIDTH || MAX_OUTSTANDING < 1) begin : g_bad_cfg
            $error("fpu_share_arbiter: invalid NB_CORES/ID_WIDTH/MAX_OUTSTANDING");
        end
    endgenerate

    arb_state_e           state_q, state_d;
    logic [CW-1:0]        rr_ptr_q;
    logic [OW-1:0]        out_q;
    logic [NB_CORES-1:0]  win_onehot;
    logic [CW-1:0]        win_idx;
    logic                 win_valid;
    logic                 issue, rid_ok, rsp_ok;

    fpu_rr_arbiter #(.N(NB_CORES)) u_rr (
        .req   (core_req_i),
        .ptr   (rr_ptr_q),
        .gnt   (win_onehot),
        .idx   (win_idx),
        .valid (win_valid)
    );

    assign apu_req_o      = (state_q == ST_RUN) && win_valid
                            && (out_q < OW'(MAX_OUTSTANDING));
    assign issue          = apu_req_o && apu_gnt_i;
    assign core_gnt_o     = issue ? win_onehot : '0;
    assign apu_ID_o       = ID_WIDTH'(win_idx);
    assign apu_operands_o = core_operands_i[win_idx];
    assign apu_op_o       = core_op_i[win_idx];
    assign apu_flags_o    = core_flags_i[win_idx];

    // A response is only trusted if something is in flight and the tag maps to a core.
    assign rid_ok = 32'(apu_rID_i) < 32'(NB_CORES);
    assign rsp_ok = apu_rvalid_i && (out_q != '0) && rid_ok;

    assign halt_ack_o    = (state_q == ST_HALT);
    assign outstanding_o = out_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:   if (halt_req_i) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (!halt_req_i)
                    state_d = ST_RUN;
                else if (out_q == '0 && !apu_rvalid_i)
                    state_d = ST_HALT;
            end
            ST_HALT:  if (!halt_req_i) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            rr_ptr_q      <= '0;
            out_q         <= '0;
            err_o         <= 1'b0;
            core_rvalid_o <= '0;
            core_rdata_o  <= '0;
            core_rflags_o <= '0;
        end else begin
            state_q <= state_d;
            if (issue)
                rr_ptr_q <= (win_idx == CW'(NB_CORES - 1)) ? '0 : win_idx + CW'(1);
            if (issue && !rsp_ok)
                out_q <= out_q + OW'(1);
            else if (!issue && rsp_ok)
                out_q <= out_q - OW'(1);
            if (apu_rvalid_i && !rsp_ok)
                err_o <= 1'b1;
            for (int c = 0; c < NB_CORES; c++)
                core_rvalid_o[c] <= rsp_ok && (32'(apu_rID_i) == 32'(c));
            if (rsp_ok) begin
                core_rdata_o  <= apu_rdata_i;
                core_rflags_o <= apu_rflags_i;
            end
        end
    end

`ifdef FPU_ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_o <= '0;
        end else begin
            for (int c = 0; c < NB_CORES; c++)
                if (core_req_i[c] && !core_gnt_o[c] && perf_stall_o[c] != '1)
                    perf_stall_o[c] <= perf_stall_o[c] + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Randomized and directed bench for fpu_share_arbiter against a cycle model.
// Define FPU_ARB_PERF_CNT_EN to also check the stall counters.
module tb_fpu_share_arbiter;

    localparam int NC  = 4;
    localparam int IW  = 9;
    localparam int NA  = 3;
    localparam int OPW = 6;
    localparam int DW  = 32;
    localparam int FIW = 15;
    localparam int FOW = 5;
    localparam int MO  = 4;
    localparam int OW  = 3;
    localparam int RUN = 0, DRAIN = 1, HALT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NC-1:0]                 core_req_i, core_gnt_o, core_rvalid_o;
    logic [NC-1:0][NA-1:0][DW-1:0] core_operands_i;
    logic [NC-1:0][OPW-1:0]        core_op_i;
    logic [NC-1:0][FIW-1:0]        core_flags_i;
    logic [DW-1:0]                 core_rdata_o, apu_rdata_i;
    logic [FOW-1:0]                core_rflags_o, apu_rflags_i;
    logic                          apu_req_o, apu_gnt_i, apu_rvalid_i;
    logic [IW-1:0]                 apu_ID_o, apu_rID_i;
    logic [NA-1:0][DW-1:0]         apu_operands_o;
    logic [OPW-1:0]                apu_op_o;
    logic [FIW-1:0]                apu_flags_o;
    logic                          halt_req_i, halt_ack_o, err_o;
    logic [OW-1:0]                 outstanding_o;
`ifdef FPU_ARB_PERF_CNT_EN
    logic [NC-1:0][31:0]           perf_stall_o;
    logic [31:0]                   m_perf [NC];
`endif

    fpu_share_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .core_req_i      (core_req_i),
        .core_gnt_o      (core_gnt_o),
        .core_operands_i (core_operands_i),
        .core_op_i       (core_op_i),
        .core_flags_i    (core_flags_i),
        .core_rvalid_o   (core_rvalid_o),
        .core_rdata_o    (core_rdata_o),
        .core_rflags_o   (core_rflags_o),
        .apu_req_o       (apu_req_o),
        .apu_gnt_i       (apu_gnt_i),
        .apu_ID_o        (apu_ID_o),
        .apu_operands_o  (apu_operands_o),
        .apu_op_o        (apu_op_o),
        .apu_flags_o     (apu_flags_o),
        .apu_rvalid_i    (apu_rvalid_i),
        .apu_rdata_i     (apu_rdata_i),
        .apu_rflags_i    (apu_rflags_i),
        .apu_rID_i       (apu_rID_i),
        .halt_req_i      (halt_req_i),
        .halt_ack_o      (halt_ack_o),
        .outstanding_o   (outstanding_o),
        .err_o           (err_o)
`ifdef FPU_ARB_PERF_CNT_EN
        ,
        .perf_stall_o    (perf_stall_o)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference state
    int             m_state, m_ptr, m_out, m_rv;
    bit             m_err;
    logic [DW-1:0]  m_rdata;
    logic [FOW-1:0] m_rflags;

    // Staged inputs, applied right after the falling edge
    bit s_rst, s_gnt, s_halt, s_rv;
    logic [NC-1:0] s_req;
    int s_rid;

    // FPU responder
    int q_id[$];
    int q_due[$];
    int issue_log[$];
    int cyc = 0;
    bit fpu_auto = 0;
    int resp_pct = 100, bad_pct = 0, lat_min = 2, lat_max = 2;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state  = RUN;
        m_ptr    = 0;
        m_out    = 0;
        m_rv     = -1;
        m_err    = 0;
        m_rdata  = '0;
        m_rflags = '0;
`ifdef FPU_ARB_PERF_CNT_EN
        for (int c = 0; c < NC; c++) m_perf[c] = '0;
`endif
    endtask

    task automatic tick();
        int w, nxt;
        bit exp_req, issue, ok;
        logic [NC-1:0] exp_gnt, exp_rv;
        @(negedge clk);
        cyc++;
        rst        = s_rst;
        core_req_i = s_req;
        apu_gnt_i  = s_gnt;
        halt_req_i = s_halt;
        for (int c = 0; c < NC; c++) begin
            core_operands_i[c] = {$urandom, $urandom, $urandom};
            core_op_i[c]       = OPW'($urandom);
            core_flags_i[c]    = FIW'($urandom);
        end
        apu_rdata_i  = $urandom;
        apu_rflags_i = FOW'($urandom);
        if (fpu_auto) begin
            apu_rvalid_i = 1'b0;
            apu_rID_i    = '0;
            if ($urandom_range(0, 99) < bad_pct) begin
                apu_rvalid_i = 1'b1;
                apu_rID_i    = IW'($urandom_range(NC, 511));
            end else if (q_id.size() > 0 && q_due[0] <= cyc
                         && $urandom_range(0, 99) < resp_pct) begin
                apu_rvalid_i = 1'b1;
                apu_rID_i    = IW'(q_id.pop_front());
                void'(q_due.pop_front());
            end
        end else begin
            apu_rvalid_i = s_rv;
            apu_rID_i    = IW'(s_rid);
            if (s_rv && q_id.size() > 0 && q_id[0] == s_rid) begin
                void'(q_id.pop_front());
                void'(q_due.pop_front());
            end
        end
        #1;
        w = -1;
        for (int i = 0; i < NC; i++)
            if (w < 0 && core_req_i[(m_ptr + i) % NC]) w = (m_ptr + i) % NC;
        exp_req = (m_state == RUN) && (w >= 0) && (m_out < MO);
        issue   = exp_req && apu_gnt_i;
        exp_gnt = issue ? (NC'(1) << w) : '0;
        exp_rv  = (m_rv >= 0) ? (NC'(1) << m_rv) : '0;

        chk("apu_req", 128'(apu_req_o), 128'(exp_req));
        chk("core_gnt", 128'(core_gnt_o), 128'(exp_gnt));
        if (exp_req) begin
            chk("apu_id", 128'(apu_ID_o), 128'(w));
            chk("apu_operands", 128'(apu_operands_o), 128'(core_operands_i[w]));
            chk("apu_op", 128'(apu_op_o), 128'(core_op_i[w]));
            chk("apu_flags", 128'(apu_flags_o), 128'(core_flags_i[w]));
        end
        chk("halt_ack", 128'(halt_ack_o), 128'(m_state == HALT));
        chk("outstanding", 128'(outstanding_o), 128'(m_out));
        chk("err", 128'(err_o), 128'(m_err));
        chk("core_rvalid", 128'(core_rvalid_o), 128'(exp_rv));
        chk("core_rdata", 128'(core_rdata_o), 128'(m_rdata));
        chk("core_rflags", 128'(core_rflags_o), 128'(m_rflags));
`ifdef FPU_ARB_PERF_CNT_EN
        for (int c = 0; c < NC; c++)
            chk("perf_stall", 128'(perf_stall_o[c]), 128'(m_perf[c]));
`endif

        if (issue) begin
            issue_log.push_back(w);
            if (!rst) begin
                q_id.push_back(w);
                q_due.push_back(cyc + $urandom_range(lat_min, lat_max));
            end
        end
        if (rst) begin
            model_reset();
        end else begin
            ok = apu_rvalid_i && m_out != 0 && apu_rID_i < NC;
            nxt = m_state;
            if (m_state == RUN && halt_req_i) nxt = DRAIN;
            if (m_state == DRAIN)
                nxt = !halt_req_i ? RUN : (m_out == 0 && !apu_rvalid_i) ? HALT : DRAIN;
            if (m_state == HALT && !halt_req_i) nxt = RUN;
`ifdef FPU_ARB_PERF_CNT_EN
            for (int c = 0; c < NC; c++)
                if (core_req_i[c] && !exp_gnt[c] && m_perf[c] != 32'hFFFF_FFFF)
                    m_perf[c]++;
`endif
            m_state = nxt;
            if (issue) m_ptr = (w + 1) % NC;
            m_out = m_out + int'(issue) - int'(ok);
            if (apu_rvalid_i && !ok) m_err = 1;
            m_rv = ok ? int'(apu_rID_i) : -1;
            if (ok) begin
                m_rdata  = apu_rdata_i;
                m_rflags = apu_rflags_i;
            end
        end
    endtask

    task automatic do_reset(input bit clear_q);
        s_rst = 1; s_req = '0; s_gnt = 0; s_halt = 0; s_rv = 0; s_rid = 0;
        fpu_auto = 0;
        tick();
        tick();
        s_rst = 0;
        if (clear_q) begin
            q_id.delete();
            q_due.delete();
        end
        issue_log.delete();
    endtask

    task automatic respond_head();
        s_rv  = 1;
        s_rid = q_id[0];
        tick();
        s_rv  = 0;
    endtask

    initial begin
        model_reset();
        rst = 1; core_req_i = '0; apu_gnt_i = 0; halt_req_i = 0;
        apu_rvalid_i = 0; apu_rID_i = '0; apu_rdata_i = '0; apu_rflags_i = '0;
        core_operands_i = '0; core_op_i = '0; core_flags_i = '0;

        // Reset state
        do_reset(1);
        tick();
        chk("rst_outstanding", 128'(outstanding_o), 128'(0));
        chk("rst_rvalid", 128'(core_rvalid_o), 128'(0));

        // All cores requesting, fixed latency of 2
        do_reset(1);
        fpu_auto = 1; resp_pct = 100; lat_min = 2; lat_max = 2;
        s_req = '1; s_gnt = 1;
        repeat (12) tick();
        chk("rr_order0", 128'(issue_log[0]), 128'(0));
        chk("rr_order1", 128'(issue_log[1]), 128'(1));
        chk("rr_order2", 128'(issue_log[2]), 128'(2));
        chk("rr_order3", 128'(issue_log[3]), 128'(3));
        chk("rr_order4", 128'(issue_log[4]), 128'(0));

        // No responses: fills to MAX_OUTSTANDING, one response frees a slot
        do_reset(1);
        s_req = '1; s_gnt = 1;
        repeat (6) tick();
        chk("full_issues", 128'(issue_log.size()), 128'(4));
        chk("full_outstanding", 128'(outstanding_o), 128'(4));
        chk("full_req", 128'(apu_req_o), 128'(0));
        respond_head();
        repeat (3) tick();
        chk("refill_issues", 128'(issue_log.size()), 128'(5));

        // Issue and response in the same cycle
        do_reset(1);
        s_req = '1; s_gnt = 1;
        repeat (2) tick();
        respond_head();
        s_req = '0;
        tick();
        chk("same_cycle_out", 128'(outstanding_o), 128'(2));

        // Halt with three in flight
        do_reset(1);
        s_req = '1; s_gnt = 1;
        repeat (2) tick();
        s_halt = 1;
        tick();
        repeat (3) tick();
        chk("drain_no_gnt", 128'(core_gnt_o), 128'(0));
        repeat (3) respond_head();
        tick();
        tick();
        chk("halt_ack", 128'(halt_ack_o), 128'(1));
        s_halt = 0;
        tick();
        tick();
        chk("resume_gnt", 128'(core_gnt_o), 128'(4'b1000));

        // Protocol errors
        do_reset(1);
        s_rv = 1; s_rid = 0;
        tick();
        s_rv = 0;
        tick();
        chk("err_empty_rv", 128'(core_rvalid_o), 128'(0));
        chk("err_empty", 128'(err_o), 128'(1));
        repeat (3) tick();
        chk("err_sticky", 128'(err_o), 128'(1));
        do_reset(1);
        s_req = 4'b0001; s_gnt = 1;
        tick();
        s_req = '0;
        s_rv = 1; s_rid = 5;
        tick();
        s_rv = 0;
        tick();
        chk("err_rid_rv", 128'(core_rvalid_o), 128'(0));
        chk("err_rid", 128'(err_o), 128'(1));
        chk("err_rid_out", 128'(outstanding_o), 128'(1));

`ifdef FPU_ARB_PERF_CNT_EN
        // Core 1 stuck behind core 0 with the FPU refusing
        do_reset(1);
        s_req = 4'b0011; s_gnt = 0;
        repeat (10) tick();
        s_req = '0;
        tick();
        chk("perf_core1", 128'(perf_stall_o[1]), 128'(10));
`endif

        // Random traffic with periodic mid-operation resets
        do_reset(1);
        fpu_auto = 1; resp_pct = 70; bad_pct = 1; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 1500; i++) begin
            s_req = NC'($urandom);
            s_gnt = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) s_halt = !s_halt;
            s_rst = (i % 300 == 299);
            tick();
        end
        s_rst = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
